stream_pixel_unpacker: RTL and testbench

STREAM_PIXEL_UNPACKER -- requirements
Module: stream_pixel_unpacker

---
 rtl/stream_pixel_unpacker_if.sv | 34 +++
 rtl/stream_pixel_unpacker.sv | 90 +++++++++
 tb/tb_stream_pixel_unpacker.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_pixel_unpacker_if.sv
// Pixel stream bundle: 32-bit input beats with tkeep/tlast/tuser framing on one side,
// and 24-bit RGB plus coordinates and frame flags with a valid/ready handshake on the other.
interface stream_pixel_unpacker_if #(
    parameter int CW = 12
);
    logic [31:0]   in_stream_data;
    logic          in_stream_valid;
    logic          in_stream_ready;
    logic [3:0]    in_stream_tkeep;
    logic          in_stream_tlast;
    logic          in_stream_tuser;
    logic [23:0]   rgb;
    logic          valid_out;
    logic          ready_out;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          first;
    logic          lastx;
    logic          lasty;

    modport slave (
        input  in_stream_data, in_stream_valid, in_stream_tkeep, in_stream_tlast, in_stream_tuser,
        input  ready_out,
        output in_stream_ready,
        output rgb, valid_out, x, y, first, lastx, lasty
    );

    modport master (
        output in_stream_data, in_stream_valid, in_stream_tkeep, in_stream_tlast, in_stream_tuser,
        output ready_out,
        input  in_stream_ready,
        input  rgb, valid_out, x, y, first, lastx, lasty
    );
endinterface

// File: rtl/stream_pixel_unpacker.sv
// Unpacks RGB pixel beats and tags them with x/y and frame flags; one register stage, latency 1.
// Input stalls only while an ACTIVE output pixel is held by ready_out=0; IDLE always accepts.
module stream_pixel_unpacker #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int CW     = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    stream_pixel_unpacker_if.slave  s,
    output logic [15:0]             frame_count,
    output logic [3:0]              err,
    input  logic                    clr_err
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [CW-1:0] XMAX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] YMAX = CW'(HEIGHT - 1);

    state_t        state;
    logic [CW-1:0] cx, cy;
    logic [CW-1:0] px, py;
    logic          accept, emit, at_xmax, at_ymax, line_end, sof_mid;
    logic [3:0]    err_set;
    logic          unused_pad;

    assign unused_pad = ^s.in_stream_data[7:0];

    assign s.in_stream_ready = reset && ((state == IDLE) || !s.valid_out || s.ready_out);
    assign accept   = s.in_stream_valid && s.in_stream_ready;
    assign emit     = accept && ((state == ACTIVE) || s.in_stream_tuser);

    // A tuser beat always restarts the coordinate space, whether it opens a frame or interrupts one.
    assign px       = s.in_stream_tuser ? '0 : cx;
    assign py       = s.in_stream_tuser ? '0 : cy;
    assign at_xmax  = (px == XMAX);
    assign at_ymax  = (py == YMAX);
    assign line_end = at_xmax || s.in_stream_tlast;
    assign sof_mid  = (state == ACTIVE) && s.in_stream_tuser && ((cx != '0) || (cy != '0));

    assign err_set[0] = emit && s.in_stream_tlast && !at_xmax;
    assign err_set[1] = emit && at_xmax && !s.in_stream_tlast;
    assign err_set[2] = emit && sof_mid;
    assign err_set[3] = accept && (s.in_stream_tkeep != 4'hF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cx          <= '0;
            cy          <= '0;
            s.valid_out <= 1'b0;
            s.rgb       <= '0;
            s.x         <= '0;
            s.y         <= '0;
            s.first     <= 1'b0;
            s.lastx     <= 1'b0;
            s.lasty     <= 1'b0;
            frame_count <= '0;
            err         <= '0;
        end else begin
            err <= (clr_err ? 4'h0 : err) | err_set;
            if (emit) begin
                s.valid_out <= 1'b1;
                s.rgb       <= s.in_stream_data[31:8];
                s.x         <= px;
                s.y         <= py;
                s.first     <= (px == '0) && (py == '0);
                s.lastx     <= at_xmax;
                s.lasty     <= at_ymax;
                if (line_end) begin
                    cx <= '0;
                    if (at_ymax) begin
                        cy          <= '0;
                        frame_count <= frame_count + 16'd1;
                        state       <= IDLE;
                    end else begin
                        cy    <= py + 1'b1;
                        state <= ACTIVE;
                    end
                end else begin
                    cx    <= px + 1'b1;
                    cy    <= py;
                    state <= ACTIVE;
                end
            end else if (s.valid_out && s.ready_out) begin
                s.valid_out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stream_pixel_unpacker.sv
// Directed bench for stream_pixel_unpacker at WIDTH=4, HEIGHT=2 with hand-computed pixel expectations.
module tb_stream_pixel_unpacker;
    logic        clk;
    logic        reset;
    logic        clr_err;
    logic [15:0] frame_count;
    logic [3:0]  err;
    int          vectors;
    int          miscompares;

    stream_pixel_unpacker_if #(.CW(12)) ifc ();

    stream_pixel_unpacker #(.WIDTH(4), .HEIGHT(2), .CW(12)) dut (
        .clk         (clk),
        .reset       (reset),
        .s           (ifc.slave),
        .frame_count (frame_count),
        .err         (err),
        .clr_err     (clr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [23:0] pc(input int i);
        return {8'h10 + 8'(i), 8'h40 + 8'(i), 8'h80 + 8'(i)};
    endfunction

    function automatic logic [31:0] pd(input int i);
        return {pc(i), 8'h5A};
    endfunction

    function automatic logic [51:0] obs();
        return {ifc.valid_out, ifc.rgb, ifc.x, ifc.y, ifc.first, ifc.lastx, ifc.lasty};
    endfunction

    function automatic logic [51:0] expp(input logic [23:0] c, input int xx, input int yy,
                                         input logic f, input logic lx, input logic ly);
        return {1'b1, c, 12'(xx), 12'(yy), f, lx, ly};
    endfunction

    task automatic do_reset();
        reset               = 1'b0;
        ifc.in_stream_valid = 1'b0;
        ifc.in_stream_data  = '0;
        ifc.in_stream_tkeep = 4'hF;
        ifc.in_stream_tlast = 1'b0;
        ifc.in_stream_tuser = 1'b0;
        ifc.ready_out       = 1'b1;
        clr_err             = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Presents one beat at posedge+1 and returns at posedge+1 after the edge that accepted it.
    task automatic drive_beat(input logic [31:0] d, input logic last, input logic user,
                              input logic [3:0] keep);
        int   n;
        logic rdy;
        n   = 0;
        rdy = 1'b0;
        ifc.in_stream_data  = d;
        ifc.in_stream_tlast = last;
        ifc.in_stream_tuser = user;
        ifc.in_stream_tkeep = keep;
        ifc.in_stream_valid = 1'b1;
        while (!rdy && n < 50) begin
            @(negedge clk);
            #4;
            rdy = ifc.in_stream_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!rdy) begin
            vectors++;
            miscompares++;
            $display("FAIL beat_timeout: in_stream_ready low for %0d cycles, required high", n);
        end
        ifc.in_stream_valid = 1'b0;
        ifc.in_stream_tlast = 1'b0;
        ifc.in_stream_tuser = 1'b0;
        ifc.in_stream_tkeep = 4'hF;
    endtask

    task automatic test_reset();
        reset               = 1'b0;
        ifc.in_stream_valid = 1'b1;
        ifc.in_stream_tuser = 1'b1;
        ifc.ready_out       = 1'b1;
        clr_err             = 1'b0;
        #1;
        vectors++;
        if (obs() !== 52'd0 || frame_count !== 16'd0 || err !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got out=%h fc=%0d err=%b, required all zero", obs(), frame_count, err);
        end
        vectors++;
        if (ifc.in_stream_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready: got %b, required 0", ifc.in_stream_ready);
        end
        ifc.in_stream_valid = 1'b0;
        ifc.in_stream_tuser = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if (ifc.in_stream_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_ready: got %b, required 1", ifc.in_stream_ready);
        end
    endtask

    task automatic test_clean_frame(input int junk);
        do_reset();
        for (int j = 0; j < junk; j++) begin
            drive_beat(pd(20 + j), 1'b0, 1'b0, 4'hF);
            vectors++;
            if (ifc.valid_out !== 1'b0) begin
                miscompares++;
                $display("FAIL junk_beat_%0d: valid_out=%b, required 0", j, ifc.valid_out);
            end
        end
        for (int i = 0; i < 8; i++) begin
            drive_beat(pd(i), (i == 3 || i == 7), (i == 0), 4'hF);
            vectors++;
            if (obs() !== expp(pc(i), i % 4, i / 4, i == 0, (i % 4) == 3, (i / 4) == 1)) begin
                miscompares++;
                $display("FAIL clean_pixel_%0d: got %h, required %h", i, obs(),
                         expp(pc(i), i % 4, i / 4, i == 0, (i % 4) == 3, (i / 4) == 1));
            end
        end
        @(posedge clk);
        #1;
        vectors++;
        if (ifc.valid_out !== 1'b0 || frame_count !== 16'd1 || err !== 4'd0) begin
            miscompares++;
            $display("FAIL clean_end: valid_out=%b fc=%0d err=%b, required 0 1 0000",
                     ifc.valid_out, frame_count, err);
        end
    endtask

    task automatic test_backpressure();
        logic        pat [4];
        logic [51:0] saved;
        logic        prev_stall;
        int          got;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        prev_stall = 1'b0;
        saved      = '0;
        got        = 0;
        do_reset();
        fork
            begin
                for (int i = 0; i < 8; i++)
                    drive_beat(pd(40 + i), (i == 3 || i == 7), (i == 0), 4'hF);
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    @(negedge clk);
                    if (prev_stall) begin
                        vectors++;
                        if (obs() !== saved) begin
                            miscompares++;
                            $display("FAIL stall_hold_c%0d: got %h, required %h", c, obs(), saved);
                        end
                    end
                    ifc.ready_out = pat[c % 4];
                    #1;
                    prev_stall = ifc.valid_out && !ifc.ready_out;
                    saved      = obs();
                    if (ifc.valid_out && ifc.ready_out) begin
                        vectors++;
                        if (got > 7 || obs() !== expp(pc(40 + got), got % 4, got / 4, got == 0,
                                                      (got % 4) == 3, (got / 4) == 1)) begin
                            miscompares++;
                            $display("FAIL bp_pixel_%0d: got %h", got, obs());
                        end
                        got++;
                    end
                    if (prev_stall && !(ifc.lastx && ifc.lasty)) begin
                        vectors++;
                        if (ifc.in_stream_ready !== 1'b0) begin
                            miscompares++;
                            $display("FAIL stall_ready_c%0d: got %b, required 0", c, ifc.in_stream_ready);
                        end
                    end
                end
            end
        join
        vectors++;
        if (got != 8 || frame_count !== 16'd1) begin
            miscompares++;
            $display("FAIL bp_count: got %0d pixels fc=%0d, required 8 and 1", got, frame_count);
        end
        ifc.ready_out = 1'b1;
    endtask

    task automatic test_eol_errors();
        int ex [6];
        int ey [6];
        ex[0] = 0; ex[1] = 1; ex[2] = 0; ex[3] = 1; ex[4] = 2; ex[5] = 3;
        ey[0] = 0; ey[1] = 0; ey[2] = 1; ey[3] = 1; ey[4] = 1; ey[5] = 1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive_beat(pd(60 + i), (i == 1), (i == 0), 4'hF);
            vectors++;
            if (obs() !== expp(pc(60 + i), ex[i], ey[i], i == 0, ex[i] == 3, ey[i] == 1)) begin
                miscompares++;
                $display("FAIL eol_pixel_%0d: got %h, required %h", i, obs(),
                         expp(pc(60 + i), ex[i], ey[i], i == 0, ex[i] == 3, ey[i] == 1));
            end
        end
        vectors++;
        if (err !== 4'b0011 || frame_count !== 16'd1) begin
            miscompares++;
            $display("FAIL eol_flags: err=%b fc=%0d, required 0011 and 1", err, frame_count);
        end
    endtask

    task automatic test_mid_sof();
        do_reset();
        drive_beat(pd(80), 1'b0, 1'b1, 4'hF);
        drive_beat(pd(81), 1'b0, 1'b0, 4'hF);
        drive_beat(pd(82), 1'b0, 1'b1, 4'hF);
        vectors++;
        if (obs() !== expp(pc(82), 0, 0, 1'b1, 1'b0, 1'b0) || err !== 4'b0100 || frame_count !== 16'd0) begin
            miscompares++;
            $display("FAIL mid_sof: got %h err=%b fc=%0d, required %h 0100 0", obs(), err, frame_count,
                     expp(pc(82), 0, 0, 1'b1, 1'b0, 1'b0));
        end
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        vectors++;
        if (err !== 4'b0000) begin
            miscompares++;
            $display("FAIL clr_err: got %b, required 0000", err);
        end
        clr_err = 1'b1;
        drive_beat(pd(83), 1'b0, 1'b0, 4'h7);
        clr_err = 1'b0;
        vectors++;
        if (obs() !== expp(pc(83), 1, 0, 1'b0, 1'b0, 1'b0) || err !== 4'b1000) begin
            miscompares++;
            $display("FAIL bad_keep_vs_clr: got %h err=%b, required %h 1000", obs(), err,
                     expp(pc(83), 1, 0, 1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 6; i++)
            drive_beat(pd(100 + i), (i == 3), (i == 0), 4'hF);
        vectors++;
        if (obs() !== expp(pc(105), 1, 1, 1'b0, 1'b0, 1'b1)) begin
            miscompares++;
            $display("FAIL pre_reset_pixel: got %h, required %h", obs(), expp(pc(105), 1, 1, 1'b0, 1'b0, 1'b1));
        end
        ifc.ready_out = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (obs() !== 52'd0 || frame_count !== 16'd0 || ifc.in_stream_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got out=%h fc=%0d rdy=%b, required 0 0 0",
                     obs(), frame_count, ifc.in_stream_ready);
        end
        @(posedge clk);
        #1;
        reset         = 1'b1;
        ifc.ready_out = 1'b1;
        for (int j = 0; j < 2; j++) begin
            drive_beat(pd(110 + j), 1'b0, 1'b0, 4'hF);
            vectors++;
            if (ifc.valid_out !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset_junk_%0d: valid_out=%b, required 0", j, ifc.valid_out);
            end
        end
        drive_beat(pd(112), 1'b0, 1'b1, 4'hF);
        vectors++;
        if (obs() !== expp(pc(112), 0, 0, 1'b1, 1'b0, 1'b0)) begin
            miscompares++;
            $display("FAIL post_reset_sof: got %h, required %h", obs(), expp(pc(112), 0, 0, 1'b1, 1'b0, 1'b0));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        clr_err     = 1'b0;
        ifc.in_stream_valid = 1'b0;
        ifc.in_stream_data  = '0;
        ifc.in_stream_tkeep = 4'hF;
        ifc.in_stream_tlast = 1'b0;
        ifc.in_stream_tuser = 1'b0;
        ifc.ready_out       = 1'b1;
        test_reset();
        test_clean_frame(0);
        test_backpressure();
        test_clean_frame(3);
        test_eol_errors();
        test_mid_sof();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
